// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized rx, mid-bit sampling, one-entry holding register.
// Bit period latched at start detection; sticky framing_error/overrun cleared by read_enable.
module uart_rx #(
  parameter int DATA_BITS      = 8,
  parameter int MIN_BIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [31:0]          clk_frequency,
  input  logic [31:0]          baud_rate,
  input  logic                 read_enable,
  output logic [DATA_BITS-1:0] data,
  output logic                 read_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int                 BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [31:0]        MIN_N    = 32'(MIN_BIT_CYCLES);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          n_q, n_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;

  logic [31:0] quot;
  logic [31:0] n_calc;
  logic [31:0] half_n;
  logic        commit;
  logic        fe_set;

  // Divisor is forced non-zero so the quotient is never evaluated against zero.
  always_comb begin
    quot   = clk_frequency / ((baud_rate == 32'd0) ? 32'd1 : baud_rate);
    n_calc = quot;
    if (baud_rate == 32'd0 || quot < MIN_N) n_calc = MIN_N;
  end

  assign half_n = n_q >> 1;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    commit    = 1'b0;
    fe_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          n_d     = n_calc;
          cnt_d   = 32'd0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == half_n - 32'd1) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = 32'd0;
            bit_d   = '0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DATA: begin
        if (cnt_q == n_q - 32'd1) begin
          shift_d[bit_q] = rx_s_q;
          cnt_d          = 32'd0;
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      STOP: begin
        if (cnt_q == n_q - 32'd1) begin
          cnt_d = 32'd0;
          if (rx_s_q) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    if (read_enable) begin
      ready_d = 1'b0;
      fe_d    = 1'b0;
      ovr_d   = 1'b0;
    end
    if (commit) begin
      data_d  = shift_q;
      ready_d = 1'b1;
      if (ready_q && !read_enable) ovr_d = 1'b1;
    end
    if (fe_set) fe_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= 32'd0;
      n_q       <= MIN_N;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data          = data_q;
  assign read_ready    = ready_q;
  assign framing_error = fe_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 160 Hz / 10 baud (16 clk per bit), plus a baud_rate = 0 case.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [31:0] clk_frequency = 32'd160;
  logic [31:0] baud_rate = 32'd10;
  logic        read_enable = 1'b0;
  logic [7:0]  data;
  logic        read_ready;
  logic        framing_error;
  logic        overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_rx dut (
    .clk(clk), .rst(rst), .rx(rx), .clk_frequency(clk_frequency), .baud_rate(baud_rate),
    .read_enable(read_enable), .data(data), .read_ready(read_ready),
    .framing_error(framing_error), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Every task is entered and left 1 time unit after a rising clk edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int nb);
    rx = 1'b0;
    tick(nb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(nb);
    end
    rx = stop;
    tick(nb);
  endtask

  task automatic pulse_read();
    read_enable = 1'b1;
    tick(1);
    read_enable = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", data); end
    checks++; if ({read_ready, framing_error, overrun, busy} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags: got %b expected 0000", {read_ready, framing_error, overrun, busy}); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_basic_latency();
    int first = -1;
    fork
      send_frame(8'hA5, 1'b1, 16);
      for (int c = 1; c <= 200; c++) begin
        @(posedge clk);
        #1;
        if (read_ready === 1'b1 && first < 0) first = c;
      end
    join
    checks++; if (first < 152 || first > 156) begin errors++; $display("FAIL a5_latency: got %0d expected 152..156", first); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h expected a5", data); end
    checks++; if ({framing_error, overrun, busy} !== 3'b000) begin
      errors++; $display("FAIL a5_flags: got %b expected 000", {framing_error, overrun, busy}); end
  endtask

  task automatic test_glitch();
    logic seen_busy = 1'b0;
    for (int c = 0; c < 24; c++) begin
      rx = (c < 4) ? 1'b0 : 1'b1;
      tick(1);
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b expected 1", seen_busy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", busy); end
    checks++; if ({read_ready, framing_error, overrun} !== 3'b100 || data !== 8'hA5) begin
      errors++; $display("FAIL glitch_unchanged: got rdy/fe/ov %b data %h expected 100 a5", {read_ready, framing_error, overrun}, data); end
    pulse_read();
    checks++; if (read_ready !== 1'b0 || data !== 8'hA5) begin
      errors++; $display("FAIL read_clear: got rdy %b data %h expected 0 a5", read_ready, data); end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 16);
    tick(40);
    checks++; if ({framing_error, read_ready, busy} !== 3'b101) begin
      errors++; $display("FAIL fe_break: got fe/rdy/busy %b expected 101", {framing_error, read_ready, busy}); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL fe_data_kept: got %h expected a5", data); end
    rx = 1'b1;
    tick(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_release: got busy %b expected 0", busy); end
    send_frame(8'h55, 1'b1, 16);
    tick(2);
    checks++; if (data !== 8'h55 || read_ready !== 1'b1) begin
      errors++; $display("FAIL fe_next_byte: got data %h rdy %b expected 55 1", data, read_ready); end
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL fe_sticky: got %b expected 1", framing_error); end
    pulse_read();
    checks++; if ({read_ready, framing_error} !== 2'b00) begin
      errors++; $display("FAIL fe_clear: got rdy/fe %b expected 00", {read_ready, framing_error}); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 16);
    checks++; if (read_ready !== 1'b1 || overrun !== 1'b0 || data !== 8'h11) begin
      errors++; $display("FAIL ovr_first: got rdy %b ov %b data %h expected 1 0 11", read_ready, overrun, data); end
    send_frame(8'h22, 1'b1, 16);
    checks++; if (overrun !== 1'b1 || data !== 8'h22 || read_ready !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got ov %b data %h rdy %b expected 1 22 1", overrun, data, read_ready); end
    pulse_read();
    checks++; if ({read_ready, overrun} !== 2'b00 || data !== 8'h22) begin
      errors++; $display("FAIL ovr_clear: got rdy/ov %b data %h expected 00 22", {read_ready, overrun}, data); end
  endtask

  task automatic test_back_to_back_read();
    send_frame(8'h11, 1'b1, 16);
    // Commit happens in the cycle ending 2 sync + 1 detect + H + 9N = 155 edges after the start edge.
    fork
      send_frame(8'h77, 1'b1, 16);
      begin
        tick(154);
        read_enable = 1'b1;
        tick(1);
        read_enable = 1'b0;
      end
    join
    checks++; if (read_ready !== 1'b1 || data !== 8'h77) begin
      errors++; $display("FAIL simul_ready: got rdy %b data %h expected 1 77", read_ready, data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_no_ovr: got %b expected 0", overrun); end
  endtask

  task automatic test_async_reset();
    rx = 1'b0;
    tick(48);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_frame_busy: got %b expected 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (data !== 8'h00 || {read_ready, framing_error, overrun, busy} !== 4'b0000) begin
      errors++; $display("FAIL async_rst: got data %h flags %b expected 00 0000", data, {read_ready, framing_error, overrun, busy}); end
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(3);
    send_frame(8'h81, 1'b1, 16);
    tick(2);
    checks++; if (data !== 8'h81 || read_ready !== 1'b1 || framing_error !== 1'b0) begin
      errors++; $display("FAIL post_rst_byte: got data %h rdy %b fe %b expected 81 1 0", data, read_ready, framing_error); end
  endtask

  task automatic test_min_period();
    pulse_read();
    baud_rate = 32'd0;
    tick(4);
    send_frame(8'hF0, 1'b1, 2);
    tick(4);
    checks++; if (data !== 8'hF0 || read_ready !== 1'b1) begin
      errors++; $display("FAIL baud0_byte: got data %h rdy %b expected f0 1", data, read_ready); end
    checks++; if ({framing_error, overrun, busy} !== 3'b000) begin
      errors++; $display("FAIL baud0_flags: got %b expected 000", {framing_error, overrun, busy}); end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back_read();
    test_async_reset();
    test_min_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
